// File: rtl/vending_credit_fsm.sv
// vending_credit_fsm: coin credit accumulator and item vend controller.
// Returns change one paced coin at a time, largest coin first.
module vending_credit_fsm #(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = 2,
    parameter int PRICE      = 35,
    parameter int MAX_CREDIT = 100,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_nickel,
    input  logic                coin_dime,
    input  logic                coin_quarter,
    input  logic                btn_select,
    input  logic [ITEM_W-1:0]   item_sel,
    input  logic                btn_cancel,
    input  logic                vend_ack,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_valid,
    output logic [ITEM_W-1:0]   vend_item,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                insufficient,
    output logic [2:0]          state_code
);
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        CREDIT = 3'b001,
        VEND   = 3'b100,
        CHANGE = 3'b101
    } state_t;

    localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
    logic                vend_valid_q, vend_valid_d;
    logic [ITEM_W-1:0]   vend_item_q, vend_item_d;
    logic                change_valid_q, change_valid_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sold_out_q, sold_out_d;
    logic                insufficient_q, insufficient_d;

    logic [CREDIT_W-1:0] coin_val, chg_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                any_coin, multi_coin, item_valid, cancel_go, vend_go;
    logic [STOCK_W-1:0]  sel_stock;

    assign coin_val   = coin_quarter ? QUARTER_C : coin_dime ? DIME_C : coin_nickel ? NICKEL_C : '0;
    assign any_coin   = coin_nickel | coin_dime | coin_quarter;
    assign multi_coin = (coin_nickel & coin_dime) | (coin_nickel & coin_quarter) | (coin_dime & coin_quarter);
    assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
    assign chg_val    = credit_q >= QUARTER_C ? QUARTER_C : credit_q >= DIME_C ? DIME_C : NICKEL_C;
    assign item_valid = int'(item_sel) < NUM_ITEMS;

    always_comb begin
        sel_stock = '0;
        for (int i = 0; i < NUM_ITEMS; i++)
            if (int'(item_sel) == i) sel_stock = stock_q[i];
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        stock_d        = stock_q;
        vend_valid_d   = vend_valid_q;
        vend_item_d    = vend_item_q;
        change_valid_d = change_valid_q;
        coin_reject_d  = 1'b0;
        sold_out_d     = 1'b0;
        insufficient_d = 1'b0;
        cancel_go      = 1'b0;
        vend_go        = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                cancel_go = state_q == CREDIT && btn_cancel && credit_q != '0;
                if (cancel_go) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    coin_reject_d  = any_coin;
                end else begin
                    if (state_q == CREDIT && btn_select) begin
                        if (credit_q < PRICE_C) insufficient_d = 1'b1;
                        else if (!item_valid || sel_stock == '0) sold_out_d = 1'b1;
                        else vend_go = 1'b1;
                    end
                    if (vend_go) begin
                        state_d       = VEND;
                        credit_d      = credit_q - PRICE_C;
                        vend_item_d   = item_sel;
                        vend_valid_d  = 1'b1;
                        coin_reject_d = any_coin;
                    end else if (any_coin) begin
                        if (coin_sum <= MAX_C) begin
                            credit_d      = coin_sum[CREDIT_W-1:0];
                            state_d       = CREDIT;
                            coin_reject_d = multi_coin;
                        end else coin_reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_reject_d = any_coin;
                if (vend_ack) begin
                    vend_valid_d = 1'b0;
                    for (int i = 0; i < NUM_ITEMS; i++)
                        if (int'(vend_item_q) == i && stock_q[i] != '0) stock_d[i] = stock_q[i] - STOCK_W'(1);
                    state_d        = credit_q != '0 ? CHANGE : IDLE;
                    change_valid_d = credit_q != '0;
                end
            end
            CHANGE: begin
                coin_reject_d = any_coin;
                if (change_valid_q && change_ack) begin
                    credit_d       = credit_q - chg_val;
                    change_valid_d = 1'b0;
                    if (credit_q == chg_val) state_d = IDLE;
                end else if (!change_valid_q) begin
                    change_valid_d = credit_q != '0;
                    if (credit_q == '0) state_d = IDLE;
                end
            end
            default: begin
                state_d        = IDLE;
                credit_d       = '0;
                vend_valid_d   = 1'b0;
                change_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
            vend_valid_q   <= 1'b0;
            vend_item_q    <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            sold_out_q     <= 1'b0;
            insufficient_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_q        <= stock_d;
            vend_valid_q   <= vend_valid_d;
            vend_item_q    <= vend_item_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            sold_out_q     <= sold_out_d;
            insufficient_q <= insufficient_d;
        end
    end

    // Coin code follows registered credit, so it cannot change while presented.
    assign change_coin  = !change_valid_q ? 2'b00 :
                          credit_q >= QUARTER_C ? 2'b11 : credit_q >= DIME_C ? 2'b10 : 2'b01;
    assign credit       = credit_q;
    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;
    assign sold_out     = sold_out_q;
    assign insufficient = insufficient_q;
    assign state_code   = state_q;
endmodule

// File: doc/vending_credit_fsm.md
Name: vending_credit_fsm

Overview:
Parametrised next-generation vending controller. Accumulates coin credit and vends one of NUM_ITEMS items at a common PRICE. Tracks per-item stock and returns change as a paced coin sequence (quarter > dime > nickel). Sits after the per-button debounce/one-shot stage and drives the dispenser, the coin hopper and the state_code LED decoder.

Parameters:
NUM_ITEMS, 4, number of selectable items.
ITEM_W, 2, width of item index; must be >= clog2(NUM_ITEMS).
PRICE, 35, item price in cents; must be a multiple of 5.
MAX_CREDIT, 100, credit ceiling in cents; must be a multiple of 5 and >= PRICE.
CREDIT_W, 8, credit register width; must hold MAX_CREDIT.
STOCK_W, 4, per-item stock counter width.
STOCK_INIT, 5, stock loaded into every item at reset.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
coin_nickel  in  1  one-cycle pulse: 5c inserted
coin_dime  in  1  one-cycle pulse: 10c inserted
coin_quarter  in  1  one-cycle pulse: 25c inserted
btn_select  in  1  one-cycle pulse: purchase request
item_sel  in  ITEM_W  item index, sampled with btn_select
btn_cancel  in  1  one-cycle pulse: refund credit
vend_ack  in  1  dispenser has taken the item
change_ack  in  1  hopper has ejected the presented coin
credit  out  CREDIT_W  current credit in cents
vend_valid  out  1  dispense request, held until acknowledged
vend_item  out  ITEM_W  item being dispensed
change_valid  out  1  coin request, held until acknowledged
change_coin  out  2  01 = nickel, 10 = dime, 11 = quarter, 00 = none
coin_reject  out  1  one-cycle pulse: coin not accepted; return it
sold_out  out  1  one-cycle pulse: selected item has zero stock
insufficient  out  1  one-cycle pulse: select with credit < PRICE
state_code  out  3  IDLE 000, CREDIT 001, VEND 100, CHANGE 101

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - Reset values: state IDLE, credit 0, every stock counter STOCK_INIT, all outputs 0 (vend_item 0, change_coin 00, state_code 000).
  - Reset asserted mid-VEND or mid-CHANGE abandons the operation; credit is lost.
- Coin handling:
  - Accepted only in IDLE and CREDIT.
  - Credit updates at the edge after the pulse, i.e. 1-cycle latency.
  - IDLE moves to CREDIT on the first accepted coin.
  - A coin whose value would push credit past MAX_CREDIT is rejected: coin_reject pulses on the next cycle and credit is unchanged.
  - Several coin pulses in one cycle: accept the highest value (quarter > dime > nickel), reject the rest with a single coin_reject pulse.
  - Any coin arriving in VEND or CHANGE produces coin_reject.
- Select (honoured in CREDIT only; ignored in IDLE, VEND and CHANGE):
  - credit < PRICE: insufficient pulses next cycle; state and credit are unchanged.
  - Stock of item_sel is 0, or item_sel >= NUM_ITEMS: sold_out pulses; credit is kept.
  - Otherwise, at the next edge: enter VEND, credit -= PRICE, latch vend_item, assert vend_valid.
- VEND:
  - vend_valid is held until vend_ack is sampled high.
  - On that edge: vend_valid drops, the item's stock decrements (no underflow), and the FSM goes to CHANGE if credit > 0, else IDLE.
  - btn_cancel and btn_select are ignored.
- Cancel:
  - In CREDIT with credit > 0: go to CHANGE.
  - Ignored in IDLE and in CREDIT with credit 0.
  - Cancel and select in the same cycle: cancel wins.
  - A coin in the same cycle as cancel is rejected.
- CHANGE:
  - change_valid is high; change_coin is the greedy largest coin <= credit (quarter if >= 25, dime if >= 10, else nickel).
  - change_coin is combinationally derived from registered credit, so it is stable while change_valid is high.
  - On change_ack: credit -= coin value, and the next coin is presented on the following cycle.
  - change_valid must deassert for at least one cycle between coins.
  - When credit reaches 0: change_valid drops, change_coin is 00, and the FSM returns to IDLE.
- Ack rules:
  - vend_ack or change_ack outside the matching valid state is ignored.
- Illegal states:
  - Any unused state encoding returns to IDLE on the next edge with credit cleared.
- Arithmetic:
  - All credit arithmetic is unsigned CREDIT_W wide.
  - Credit never wraps: the saturation check is done on a CREDIT_W+1-bit sum.

Test Plan:
- Reset; quarter then dime; select item 0 -> credit 25, then 35; vend_valid=1 with vend_item=0 and credit=0; vend_ack -> IDLE, stock[0]=4, no change cycle.
- Two quarters; select item 2 -> vend with credit 15; vend_ack -> CHANGE presents dime (10); change_ack; idle cycle; nickel (01); change_ack -> credit 0, IDLE.
- Four quarters (credit 100) then nickel -> coin_reject pulse, credit stays 100; nickel+dime+quarter in one cycle from credit 0 -> credit 25 and one coin_reject.
- STOCK_INIT=1: buy item 1 twice -> second select gives sold_out, credit retained at 35; select item 1 with credit 20 -> insufficient pulse.
- Credit 40; cancel -> quarter, dime, nickel in order, each held until change_ack; coin during CHANGE -> coin_reject.
- rst_n low during VEND with vend_valid high -> all outputs 0 immediately (asynchronous), stocks back to STOCK_INIT, state_code 000.
